// File: rtl/writeback_arbiter_pkg.sv
// Shared types and default widths for the write-back arbiter,
// the scheduler and the active list.
package writeback_arbiter_pkg;

  localparam int unsigned WB_N_SRC  = 3;
  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_TAG_W  = 6;
  localparam int unsigned WB_ID_W   = 5;
  localparam int unsigned WB_DEPTH  = 2;

  typedef struct packed {
    logic                 uses_rw;
    logic [WB_TAG_W-1:0]  rw_addr;
    logic [WB_DATA_W-1:0] rw_data;
    logic [WB_ID_W-1:0]   active_list_id;
  } wb_entry_t;

endpackage

// File: rtl/wb_source_fifo.sv
// Per-source result FIFO; count tells full from empty since the
// pointers wrap naturally over a power-of-two depth.
module wb_source_fifo
  import writeback_arbiter_pkg::*;
#(
  parameter  int unsigned DEPTH = WB_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  wb_entry_t        din,
  input  logic             pop,
  output wb_entry_t        head,
  output logic [CNT_W-1:0] count,
  output logic             ready
);

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign ready   = (cnt_q < CNT_W'(DEPTH)) && !clr;
  assign do_push = push && ready;
  assign do_pop  = pop && (cnt_q != '0) && !clr;
  assign head    = mem_q[rd_ptr_q];
  assign count   = cnt_q;

  // Next pointers, count and storage; clear wins over push/pop.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (clr) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Payload storage needs no reset; count guards stale entries.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Grants one buffered result per cycle onto the write-back port.
// Define WB_ARBITER_ROUND_ROBIN_EN for round-robin, else fixed priority.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter  int unsigned N_SRC  = WB_N_SRC,
  parameter  int unsigned DATA_W = WB_DATA_W,
  parameter  int unsigned TAG_W  = WB_TAG_W,
  parameter  int unsigned ID_W   = WB_ID_W,
  parameter  int unsigned DEPTH  = WB_DEPTH,
  localparam int unsigned SRC_W  = $clog2(N_SRC)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [N_SRC-1:0]        req_valid,
  output logic [N_SRC-1:0]        req_ready,
  input  logic [N_SRC-1:0]        req_uses_rw,
  input  logic [N_SRC*TAG_W-1:0]  req_rw_addr,
  input  logic [N_SRC*DATA_W-1:0] req_rw_data,
  input  logic [N_SRC*ID_W-1:0]   req_active_list_id,
  output logic                    wb_valid,
  output logic                    wb_uses_rw,
  output logic [TAG_W-1:0]        wb_rw_addr,
  output logic [DATA_W-1:0]       wb_rw_data,
  output logic [ID_W-1:0]         wb_active_list_id,
  output logic [SRC_W-1:0]        wb_src
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  wb_entry_t        din  [N_SRC];
  wb_entry_t        head [N_SRC];
  logic [CNT_W-1:0] cnt  [N_SRC];
  logic [N_SRC-1:0] push, pop, nonempty;

  logic             gnt_vld;
  logic [SRC_W-1:0] gnt_idx;

  logic             wb_valid_q, wb_valid_d;
  logic [SRC_W-1:0] wb_src_q, wb_src_d;
  wb_entry_t        wb_ent_q, wb_ent_d;

  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
    assign din[gi] = wb_entry_t'{
      uses_rw:        req_uses_rw[gi],
      rw_addr:        req_rw_addr[gi*TAG_W +: TAG_W],
      rw_data:        req_rw_data[gi*DATA_W +: DATA_W],
      active_list_id: req_active_list_id[gi*ID_W +: ID_W]
    };
    assign push[gi]     = req_valid[gi] & req_ready[gi];
    assign nonempty[gi] = cnt[gi] != '0;

    wb_source_fifo #(
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (flush),
      .push  (push[gi]),
      .din   (din[gi]),
      .pop   (pop[gi]),
      .head  (head[gi]),
      .count (cnt[gi]),
      .ready (req_ready[gi])
    );
  end

`ifdef WB_ARBITER_ROUND_ROBIN_EN
  logic [SRC_W-1:0] last_q, last_d;
  logic [SRC_W-1:0] cand;

  // Rotating search starting one past the last granted source.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      cand = SRC_W'((32'(last_q) + 1 + k) % N_SRC);
      if (!gnt_vld && nonempty[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // Pointer follows grants; recovery parks it so source 0 is next.
  always_comb begin
    last_d = last_q;
    if (flush) begin
      last_d = SRC_W'(N_SRC - 1);
    end else if (gnt_vld) begin
      last_d = gnt_idx;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= SRC_W'(N_SRC - 1);
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Fixed priority: lowest non-empty index wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (!gnt_vld && nonempty[SRC_W'(i)]) begin
        gnt_vld = 1'b1;
        gnt_idx = SRC_W'(i);
      end
    end
  end
`endif

  // Dequeue the granted head unless recovery drops the grant.
  always_comb begin
    pop = '0;
    if (gnt_vld && !flush) begin
      pop[gnt_idx] = 1'b1;
    end
  end

  // Next write-back beat; payload holds when nothing is granted.
  always_comb begin
    wb_valid_d = 1'b0;
    wb_src_d   = wb_src_q;
    wb_ent_d   = wb_ent_q;
    if (gnt_vld && !flush) begin
      wb_valid_d = 1'b1;
      wb_src_d   = gnt_idx;
      wb_ent_d   = head[gnt_idx];
    end
  end

  // Registered write-back/commit beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      wb_src_q   <= '0;
      wb_ent_q   <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_src_q   <= wb_src_d;
      wb_ent_q   <= wb_ent_d;
    end
  end

  assign wb_valid          = wb_valid_q;
  assign wb_src            = wb_src_q;
  assign wb_uses_rw        = wb_ent_q.uses_rw;
  assign wb_rw_addr        = wb_ent_q.rw_addr;
  assign wb_rw_data        = wb_ent_q.rw_data;
  assign wb_active_list_id = wb_ent_q.active_list_id;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios plus random traffic
// checked against a queue-based model of the arbitration rules.
module tb_writeback_arbiter;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int TW = 6;
  localparam int IW = 5;
  localparam int D  = 2;

  logic            clk = 1'b0;
  logic            rst, flush;
  logic [N-1:0]    req_valid, req_ready, req_uses_rw;
  logic [N*TW-1:0] req_rw_addr;
  logic [N*DW-1:0] req_rw_data;
  logic [N*IW-1:0] req_active_list_id;
  logic            wb_valid, wb_uses_rw;
  logic [TW-1:0]   wb_rw_addr;
  logic [DW-1:0]   wb_rw_data;
  logic [IW-1:0]   wb_active_list_id;
  logic [1:0]      wb_src;

  writeback_arbiter #(
    .N_SRC (N), .DATA_W (DW), .TAG_W (TW), .ID_W (IW), .DEPTH (D)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .flush              (flush),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_uses_rw        (req_uses_rw),
    .req_rw_addr        (req_rw_addr),
    .req_rw_data        (req_rw_data),
    .req_active_list_id (req_active_list_id),
    .wb_valid           (wb_valid),
    .wb_uses_rw         (wb_uses_rw),
    .wb_rw_addr         (wb_rw_addr),
    .wb_rw_data         (wb_rw_data),
    .wb_active_list_id  (wb_active_list_id),
    .wb_src             (wb_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          u;
    bit [TW-1:0] a;
    bit [DW-1:0] d;
    bit [IW-1:0] id;
  } ent_t;

  ent_t mq [N][$];
  int   last_g;

  bit          e_valid, e_u;
  bit [TW-1:0] e_a;
  bit [DW-1:0] e_d;
  bit [IW-1:0] e_id;
  bit [1:0]    e_src;
  bit [N-1:0]  e_ready, acc;
  logic [N-1:0] o_ready;

  ent_t pend   [N];
  bit   pend_v [N];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]                   = pend_v[i];
      req_uses_rw[i]                 = pend[i].u;
      req_rw_addr[i*TW +: TW]        = pend[i].a;
      req_rw_data[i*DW +: DW]        = pend[i].d;
      req_active_list_id[i*IW +: IW] = pend[i].id;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) mq[i].delete();
    last_g  = N - 1;
    e_valid = 0; e_u = 0; e_a = '0; e_d = '0; e_id = '0; e_src = '0;
  endtask

  // One clock: model the coming edge from the driven inputs, then step.
  task automatic cycle();
    int   g;
    int   s;
    ent_t e;
    #1;
    o_ready = req_ready;
    for (int i = 0; i < N; i++)
      e_ready[i] = (mq[i].size() < D) && !flush;
    acc = '0;
    if (rst) begin
      model_reset();
    end else if (flush) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      last_g  = N - 1;
      e_valid = 0;
    end else begin
      g = -1;
`ifdef WB_ARBITER_ROUND_ROBIN_EN
      for (int k = 0; k < N; k++) begin
        s = (last_g + 1 + k) % N;
        if (g < 0 && mq[s].size() > 0) g = s;
      end
`else
      for (s = 0; s < N; s++)
        if (g < 0 && mq[s].size() > 0) g = s;
`endif
      if (g >= 0) begin
        e       = mq[g].pop_front();
        e_valid = 1; e_u = e.u; e_a = e.a; e_d = e.d; e_id = e.id;
        e_src   = 2'(g);
        last_g  = g;
      end else begin
        e_valid = 0;
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && e_ready[i]) begin
          e.u  = req_uses_rw[i];
          e.a  = req_rw_addr[i*TW +: TW];
          e.d  = req_rw_data[i*DW +: DW];
          e.id = req_active_list_id[i*IW +: IW];
          mq[i].push_back(e);
          acc[i] = 1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    for (int i = 0; i < N; i++) if (acc[i]) pend_v[i] = 0;
  endtask

  task automatic do_flush();
    flush = 1;
    for (int i = 0; i < N; i++) pend_v[i] = 0;
    drive();
    cycle();
    flush = 0;
  endtask

  task automatic test_reset();
    rst = 1; flush = 0;
    for (int i = 0; i < N; i++) begin
      pend_v[i] = 0;
      pend[i]   = '{0, '0, '0, '0};
    end
    drive();
    cycle();
    cycle();
    n_cmp++;
    if ({wb_valid, wb_uses_rw, wb_rw_addr, wb_rw_data,
         wb_active_list_id, wb_src} !== '0) begin
      n_err++;
      $display("FAIL reset_wb: got v=%b u=%b a=%0d d=%h id=%0d src=%0d, need all 0",
               wb_valid, wb_uses_rw, wb_rw_addr, wb_rw_data,
               wb_active_list_id, wb_src);
    end
    rst = 0;
    #1;
    n_cmp++;
    if (req_ready !== 3'b111) begin
      n_err++;
      $display("FAIL reset_ready: got %b need 111", req_ready);
    end
  endtask

  task automatic test_single_alu();
    pend[0]   = '{1, 6'd12, 32'hDEADBEEF, 5'd3};
    pend_v[0] = 1;
    drive();
    cycle();
    n_cmp++;
    if (o_ready[0] !== 1'b1 || wb_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_t1: ready=%b wb_valid=%b need 1/0", o_ready[0], wb_valid);
    end
    drive();
    cycle();
    n_cmp++;
    if (wb_valid !== 1'b1 || wb_uses_rw !== 1'b1 || wb_rw_addr !== 6'd12 ||
        wb_rw_data !== 32'hDEADBEEF || wb_active_list_id !== 5'd3 ||
        wb_src !== 2'd0) begin
      n_err++;
      $display("FAIL single_t2: got v=%b u=%b a=%0d d=%h id=%0d src=%0d need 1 1 12 deadbeef 3 0",
               wb_valid, wb_uses_rw, wb_rw_addr, wb_rw_data,
               wb_active_list_id, wb_src);
    end
    drive();
    cycle();
    n_cmp++;
    if (wb_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_t3: wb_valid=%b need 0", wb_valid);
    end
  endtask

  task automatic test_burst();
    int exp_src [6];
    int exp_id  [6];
`ifdef WB_ARBITER_ROUND_ROBIN_EN
    exp_src = '{0, 1, 2, 0, 1, 2};
    exp_id  = '{10, 11, 12, 20, 21, 22};
`else
    exp_src = '{0, 0, 1, 1, 2, 2};
    exp_id  = '{10, 20, 11, 21, 12, 22};
`endif
    do_flush();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) begin
        pend[i]   = '{1, TW'(i + 1), DW'($urandom), IW'(10 * (r + 1) + i)};
        pend_v[i] = 1;
      end
      drive();
      cycle();
    end
    for (int b = 0; b < 6; b++) begin
      n_cmp++;
      if (wb_valid !== 1'b1 || wb_src !== 2'(exp_src[b]) ||
          wb_active_list_id !== IW'(exp_id[b])) begin
        n_err++;
        $display("FAIL burst_beat%0d: got v=%b src=%0d id=%0d need 1 %0d %0d",
                 b, wb_valid, wb_src, wb_active_list_id, exp_src[b], exp_id[b]);
      end
      drive();
      cycle();
    end
    n_cmp++;
    if (wb_valid !== 1'b0) begin
      n_err++;
      $display("FAIL burst_end: wb_valid=%b need 0", wb_valid);
    end
  endtask

  task automatic test_backpressure();
    int load_sent = 0;
    int load_acc  = 0;
    int load_wb   = 0;
    int c         = 0;
    do_flush();
    while (c < 60 && (load_acc < 3 || c < 20)) begin
      if (!pend_v[0] && c < 8) begin
        pend[0]   = '{1, TW'($urandom), DW'($urandom), IW'($urandom)};
        pend_v[0] = 1;
      end
      if (!pend_v[1] && load_sent < 3) begin
        pend[1]   = '{1, TW'(40 + load_sent), DW'($urandom), IW'(load_sent)};
        pend_v[1] = 1;
        load_sent++;
      end
      drive();
      cycle();
      if (acc[1]) load_acc++;
      if (wb_valid === 1'b1 && wb_src === 2'd1) load_wb++;
      if (c == 2) begin
        n_cmp++;
        if (o_ready[1] !== 1'b0 || acc[1]) begin
          n_err++;
          $display("FAIL bp_full: ready1=%b accepted=%b need 0 0", o_ready[1], acc[1]);
        end
      end
      n_cmp++;
      if (o_ready !== e_ready || wb_valid !== e_valid || wb_src !== e_src ||
          wb_rw_addr !== e_a || wb_rw_data !== e_d ||
          wb_active_list_id !== e_id || wb_uses_rw !== e_u) begin
        n_err++;
        $display("FAIL bp_cyc%0d: got rdy=%b v=%b src=%0d a=%0d d=%h id=%0d need rdy=%b v=%b src=%0d a=%0d d=%h id=%0d",
                 c, o_ready, wb_valid, wb_src, wb_rw_addr, wb_rw_data,
                 wb_active_list_id, e_ready, e_valid, e_src, e_a, e_d, e_id);
      end
      c++;
    end
    n_cmp++;
    if (load_acc != 3 || load_wb != 3) begin
      n_err++;
      $display("FAIL bp_count: load accepted=%0d written=%0d need 3 3", load_acc, load_wb);
    end
  endtask

  task automatic test_flush();
    do_flush();
    for (int i = 0; i < N; i++) begin
      pend[i]   = '{1, TW'(i), DW'($urandom), IW'(i)};
      pend_v[i] = 1;
    end
    drive();
    cycle();
    for (int i = 1; i < N; i++) begin
      pend[i]   = '{1, TW'(i + 4), DW'($urandom), IW'(i + 4)};
      pend_v[i] = 1;
    end
    drive();
    cycle();
    flush = 1;
    for (int i = 0; i < N; i++) begin
      pend[i]   = '{1, 6'd63, 32'hBAD0BAD0, 5'd31};
      pend_v[i] = 1;
    end
    drive();
    cycle();
    flush = 0;
    n_cmp++;
    if (o_ready !== 3'b000 || wb_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_edge: ready=%b wb_valid=%b need 000 0", o_ready, wb_valid);
    end
    for (int i = 0; i < N; i++) pend_v[i] = 0;
    drive();
    cycle();
    n_cmp++;
    if (o_ready !== 3'b111) begin
      n_err++;
      $display("FAIL flush_ready: got %b need 111", o_ready);
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (wb_valid !== 1'b0) begin
        n_err++;
        $display("FAIL flush_quiet%0d: wb_valid=%b id=%0d need 0", k, wb_valid, wb_active_list_id);
      end
      drive();
      cycle();
    end
  endtask

  task automatic test_push_pop();
    do_flush();
    pend[0]   = '{1, 6'd7, 32'h0000_0007, 5'd7};
    pend_v[0] = 1;
    drive();
    cycle();
    pend[0]   = '{0, 6'd8, 32'h0000_0008, 5'd8};
    pend_v[0] = 1;
    drive();
    cycle();
    n_cmp++;
    if (o_ready[0] !== 1'b1 || !acc[0] || wb_valid !== 1'b1 ||
        wb_active_list_id !== 5'd7 || wb_rw_data !== 32'h7) begin
      n_err++;
      $display("FAIL pp_old: rdy=%b v=%b id=%0d d=%h need 1 1 7 7",
               o_ready[0], wb_valid, wb_active_list_id, wb_rw_data);
    end
    drive();
    cycle();
    n_cmp++;
    if (wb_valid !== 1'b1 || wb_active_list_id !== 5'd8 ||
        wb_uses_rw !== 1'b0 || wb_src !== 2'd0) begin
      n_err++;
      $display("FAIL pp_new: v=%b id=%0d u=%b src=%0d need 1 8 0 0",
               wb_valid, wb_active_list_id, wb_uses_rw, wb_src);
    end
    drive();
    cycle();
    n_cmp++;
    if (wb_valid !== 1'b0) begin
      n_err++;
      $display("FAIL pp_empty: wb_valid=%b need 0", wb_valid);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend_v[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = '{bit'($urandom_range(0, 1)), TW'($urandom),
                      DW'($urandom), IW'($urandom)};
          pend_v[i] = 1;
        end
      end
      flush = ($urandom_range(0, 39) == 0);
      drive();
      cycle();
      if (flush) for (int i = 0; i < N; i++) pend_v[i] = 0;
      flush = 0;
      n_cmp++;
      if (o_ready !== e_ready || wb_valid !== e_valid || wb_src !== e_src ||
          wb_uses_rw !== e_u || wb_rw_addr !== e_a || wb_rw_data !== e_d ||
          wb_active_list_id !== e_id) begin
        n_err++;
        $display("FAIL rand_cyc%0d: got rdy=%b v=%b src=%0d u=%b a=%0d d=%h id=%0d need rdy=%b v=%b src=%0d u=%b a=%0d d=%h id=%0d",
                 c, o_ready, wb_valid, wb_src, wb_uses_rw, wb_rw_addr,
                 wb_rw_data, wb_active_list_id, e_ready, e_valid, e_src,
                 e_u, e_a, e_d, e_id);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_burst();
    test_backpressure();
    test_flush();
    test_push_pop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
